// File: rtl/ram_portb_arbiter_if.sv
// ram_portb_arbiter_if: one requester's load/store request channel
// and its valid/ready response channel.
interface ram_portb_arbiter_if #(
    parameter int DataW = 32,
    parameter int AddrW = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AddrW-1:0] req_addr;
    logic [2:0]       req_size;
    logic [DataW-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DataW-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter: round-robin two-master sequencer for RAM port B.
// One registered command per transaction, response held until consumed.
module ram_portb_arbiter #(
    parameter int DataW = 32,
    parameter int AddrW = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    ram_portb_arbiter_if.slave        m0,
    ram_portb_arbiter_if.slave        m1,
    output logic                      ram_re,
    output logic                      ram_we,
    output logic [AddrW-1:0]          ram_addr,
    output logic [2:0]                ram_size,
    output logic [DataW-1:0]          ram_wdt,
    input  logic [DataW-1:0]          ram_rdt
);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic               we_q, we_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [DataW-1:0]   rdata_q, rdata_d;
    logic               first_q, first_d;

    logic               idle, cmd, resp;
    logic               sel_m0, sel_m1;
    logic               req_we;
    logic [AddrW-1:0]   req_addr;
    logic [2:0]         req_size;
    logic [DataW-1:0]   req_wdata;
    logic               req_legal;
    logic               rsp_fire;
    logic [DataW-1:0]   rsp_data;

    function automatic logic legal(input logic [2:0] sz, input logic [1:0] a);
        logic ok;
        case (sz)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = !a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign idle = (state_q == IDLE);
    assign cmd  = (state_q == CMD);
    assign resp = (state_q == RESP);

    // On a tie the master that did not win last time is selected.
    assign sel_m0 = idle & m0.req_valid & (!m1.req_valid | last_grant_q);
    assign sel_m1 = idle & m1.req_valid & (!m0.req_valid | !last_grant_q);

    assign req_we    = sel_m1 ? m1.req_we    : m0.req_we;
    assign req_addr  = sel_m1 ? m1.req_addr  : m0.req_addr;
    assign req_size  = sel_m1 ? m1.req_size  : m0.req_size;
    assign req_wdata = sel_m1 ? m1.req_wdata : m0.req_wdata;
    assign req_legal = legal(req_size, req_addr[1:0]);

    // Read data is live from port B only in the first RESP cycle.
    assign rsp_data = (first_q && !we_q && !err_q) ? ram_rdt : rdata_q;
    assign rsp_fire = resp & (id_q ? m1.rsp_ready : m0.rsp_ready);

    // Next-state and request/response latching.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        first_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_m0 | sel_m1) begin
                    id_d         = sel_m1;
                    last_grant_d = sel_m1;
                    we_d         = req_we;
                    addr_d       = req_addr;
                    size_d       = req_size;
                    wdata_d      = req_wdata;
                    err_d        = !req_legal;
                    rdata_d      = '0;
                    state_d      = req_legal ? CMD : RESP;
                end
            end
            CMD: begin
                first_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rdata_d = rsp_data;
                if (rsp_fire) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            first_q      <= first_d;
        end
    end

    assign m0.req_ready = sel_m0 & reset;
    assign m1.req_ready = sel_m1 & reset;

    assign m0.rsp_valid = resp & !id_q;
    assign m1.rsp_valid = resp & id_q;
    assign m0.rsp_rdata = (resp & !id_q) ? rsp_data : '0;
    assign m1.rsp_rdata = (resp & id_q) ? rsp_data : '0;
    assign m0.rsp_err   = resp & !id_q & err_q;
    assign m1.rsp_err   = resp & id_q & err_q;

    // Enables are gated by reset so a reset in CMD never commits a write.
    assign ram_re   = reset & cmd & !we_q;
    assign ram_we   = reset & cmd & we_q;
    assign ram_addr = cmd ? addr_q : '0;
    assign ram_size = cmd ? size_q : '0;
    assign ram_wdt  = cmd ? wdata_q : '0;
endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb_ram_portb_arbiter: vector table, directed corner sequences and
// random traffic checked against a byte-array memory model.
module tb_ram_portb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ram_re, ram_we;
    logic [31:0] ram_addr;
    logic [2:0]  ram_size;
    logic [31:0] ram_wdt;
    logic [31:0] ram_rdt;

    ram_portb_arbiter_if #(.DataW(32), .AddrW(32)) m0_if ();
    ram_portb_arbiter_if #(.DataW(32), .AddrW(32)) m1_if ();

    ram_portb_arbiter #(.DataW(32), .AddrW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_re   (ram_re),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_size (ram_size),
        .ram_wdt  (ram_wdt),
        .ram_rdt  (ram_rdt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] init_byte(int i);
        logic [31:0] w;
        int base;
        base = i & ~3;
        if (base == 'h100)      w = 32'h8081_F0F2;
        else if (base == 'h200) w = 32'h5566_7788;
        else if (base == 'h300) w = 32'hDEAD_BEEF;
        else                    w = (i * 32'h0101_0101) ^ 32'h5A3C_96E1;
        return w[8*(i%4) +: 8];
    endfunction

    // Port B memory: writes at the CMD edge, registered formatted read.
    logic [7:0] mem [0:1023];
    bit         init_done = 0;

    function automatic logic [31:0] pb_load(logic [31:0] a, logic [2:0] s);
        logic [9:0]  base;
        logic [31:0] w, sh, r;
        base = {a[9:2], 2'b00};
        w  = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
        sh = w >> (8 * a[1:0]);
        case (s)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h0, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0, sh[15:0]};
            3'b010:  r = w;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
            ram_rdt <= 32'h0;
        end else begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < (ram_size[1:0] == 2'd0 ? 1 : ram_size[1:0] == 2'd1 ? 2 : 4))
                        mem[10'(ram_addr[9:0] + 10'(i))] <= ram_wdt[8*i +: 8];
                end
            end
            if (ram_re) ram_rdt <= pb_load(ram_addr, ram_size);
        end
    end

    // Sticky flags for properties that must hold on every cycle.
    bit dual_ready = 0;
    bit dual_rsp   = 0;
    always @(negedge clk) begin
        if (m0_if.req_ready && m1_if.req_ready) dual_ready <= 1'b1;
        if (m0_if.rsp_valid && m1_if.rsp_valid) dual_rsp <= 1'b1;
    end

    // Reference model: flat byte array plus the legality rules.
    logic [7:0] refmem [0:1023];

    function automatic int nbytes(logic [2:0] s);
        return (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_legal(logic [31:0] a, logic [2:0] s);
        bit known;
        known = (s == 3'd0) || (s == 3'd1) || (s == 3'd2) ||
                (s == 3'd4) || (s == 3'd5);
        return known && ((a % nbytes(s)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] s);
        longint v;
        longint half;
        int nb;
        nb = nbytes(s);
        v  = 0;
        for (int i = nb - 1; i >= 0; i--)
            v = v * 256 + longint'(refmem[(a + i) % 1024]);
        half = longint'(1) << (8 * nb - 1);
        if (!s[2] && nb < 4 && v >= half) v = v - 2 * half;
        return v[31:0];
    endfunction

    task automatic ref_store(logic [31:0] a, logic [2:0] s, logic [31:0] d);
        for (int i = 0; i < nbytes(s); i++)
            refmem[(a + i) % 1024] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_req(int m, logic v, logic we, logic [31:0] a,
                           logic [2:0] s, logic [31:0] d);
        if (m == 0) begin
            m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = a;
            m0_if.req_size = s;  m0_if.req_wdata = d;
        end else begin
            m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = a;
            m1_if.req_size = s;  m1_if.req_wdata = d;
        end
    endtask

    function automatic logic get_ready(int m);
        return (m == 0) ? m0_if.req_ready : m1_if.req_ready;
    endfunction
    function automatic logic get_rvalid(int m);
        return (m == 0) ? m0_if.rsp_valid : m1_if.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(int m);
        return (m == 0) ? m0_if.rsp_rdata : m1_if.rsp_rdata;
    endfunction
    function automatic logic get_err(int m);
        return (m == 0) ? m0_if.rsp_err : m1_if.rsp_err;
    endfunction

    // Single transaction from one master; starts and ends just after posedge.
    task automatic run_txn(input string tag, input int m, input logic we,
                           input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d, input logic [31:0] exp_rdata,
                           input logic exp_err);
        bit got;
        int lat, en;
        logic [31:0] cmd_addr;
        set_req(m, 1'b1, we, a, s, d);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (get_ready(m)) begin got = 1; break; end
        end
        chk($sformatf("%s accept", tag), 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        lat = 0; en = 0; got = 0; cmd_addr = 32'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (ram_re || ram_we) begin
                en++;
                cmd_addr = ram_addr;
                chk($sformatf("%s ram_we", tag), 32'(ram_we), 32'(we));
            end
            if (get_rvalid(m)) begin got = 1; break; end
        end
        chk($sformatf("%s rsp", tag), 32'(got), 32'd1);
        chk($sformatf("%s latency", tag), 32'(lat), exp_err ? 32'd1 : 32'd2);
        chk($sformatf("%s enables", tag), 32'(en), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) chk($sformatf("%s ram_addr", tag), cmd_addr, a);
        chk($sformatf("%s rdata", tag), get_rdata(m), exp_rdata);
        chk($sformatf("%s err", tag), 32'(get_err(m)), 32'(exp_err));
        chk($sformatf("%s other_rsp", tag), 32'(get_rvalid(1 - m)), 32'd0);
        @(posedge clk); #1;
        if (!exp_err && we) ref_store(a, s, d);
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t        vecs [11];
    logic [2:0]  sz_tab [10];
    int          order [4];

    initial begin
        bit          got;
        bit          stable;
        int          acc, prev;
        logic [31:0] r0;

        vecs[0]  = '{0, 1'b0, 32'h101, 3'b000, 32'h0,       32'hFFFF_FFF0, 1'b0};
        vecs[1]  = '{1, 1'b1, 32'h202, 3'b001, 32'h1234,    32'h0,         1'b0};
        vecs[2]  = '{1, 1'b0, 32'h202, 3'b101, 32'h0,       32'h0000_1234, 1'b0};
        vecs[3]  = '{1, 1'b0, 32'h200, 3'b101, 32'h0,       32'h0000_7788, 1'b0};
        vecs[4]  = '{0, 1'b0, 32'h103, 3'b010, 32'h0,       32'h0,         1'b1};
        vecs[5]  = '{0, 1'b0, 32'h100, 3'b011, 32'h0,       32'h0,         1'b1};
        vecs[6]  = '{0, 1'b0, 32'h100, 3'b001, 32'h0,       32'hFFFF_F0F2, 1'b0};
        vecs[7]  = '{0, 1'b0, 32'h103, 3'b100, 32'h0,       32'h0000_0080, 1'b0};
        vecs[8]  = '{1, 1'b1, 32'h204, 3'b010, 32'hA5A5_5A5A, 32'h0,       1'b0};
        vecs[9]  = '{1, 1'b0, 32'h204, 3'b010, 32'h0,       32'hA5A5_5A5A, 1'b0};
        vecs[10] = '{1, 1'b0, 32'h201, 3'b001, 32'h0,       32'h0,         1'b1};
        sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd0, 3'd3, 3'd7};

        for (int i = 0; i < 1024; i++) refmem[i] = init_byte(i);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        m0_if.rsp_ready = 1'b1;
        m1_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        init_done = 1;
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst ready", {30'h0, m0_if.req_ready, m1_if.req_ready}, 32'h0);
        chk("rst rsp_valid", {30'h0, m0_if.rsp_valid, m1_if.rsp_valid}, 32'h0);
        chk("rst ram_en", {30'h0, ram_re, ram_we}, 32'h0);
        chk("rst ram_addr", ram_addr, 32'h0);
        chk("rst rdata", m0_if.rsp_rdata | m1_if.rsp_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 11; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].we, vecs[i].addr,
                    vecs[i].size, vecs[i].wdata, vecs[i].rdata, vecs[i].err);

        // Contention: both masters keep requesting for 4 grants
        set_req(0, 1'b1, 1'b0, 32'h100, 3'b010, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h204, 3'b010, 32'h0);
        acc = 0; prev = 0;
        for (int c = 0; c < 60 && acc < 4; c++) begin
            @(negedge clk);
            if (m0_if.req_ready || m1_if.req_ready) begin
                order[acc] = m1_if.req_ready ? 1 : 0;
                if (acc > 0) chk($sformatf("cont spacing%0d", acc), 32'(c - prev), 32'd3);
                prev = c;
                acc++;
                if (acc == 4) begin
                    @(posedge clk); #1;
                    set_req(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
                    set_req(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
                end
            end
        end
        chk("cont grants", 32'(acc), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cont order%0d", i), 32'(order[i]), 32'(i % 2));
        repeat (5) @(posedge clk);
        #1;

        // Backpressure on M0 while M1 waits
        m0_if.rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h100, 3'b010, 32'h0);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m0_if.req_ready) begin got = 1; break; end
        end
        chk("bp accept0", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h200, 3'b101, 32'h0);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m0_if.rsp_valid) begin got = 1; break; end
        end
        chk("bp rsp0", 32'(got), 32'd1);
        r0 = m0_if.rsp_rdata;
        chk("bp rdata0", r0, 32'h8081_F0F2);
        stable = 1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (!m0_if.rsp_valid || m0_if.rsp_rdata !== r0 || m0_if.rsp_err ||
                ram_re || ram_we || m1_if.req_ready)
                stable = 0;
        end
        chk("bp stall stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        m0_if.rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m1_if.req_ready) begin got = 1; break; end
        end
        chk("bp accept1", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m1_if.rsp_valid) begin got = 1; break; end
        end
        chk("bp rsp1", 32'(got), 32'd1);
        chk("bp rdata1", m1_if.rsp_rdata, 32'h0000_7788);
        @(posedge clk); #1;

        // Reset during CMD of a store
        set_req(0, 1'b1, 1'b1, 32'h300, 3'b010, 32'hCAFE_BABE);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m0_if.req_ready) begin got = 1; break; end
        end
        chk("rcmd accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rcmd ram_we", {30'h0, ram_re, ram_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rcmd rsp_valid", {30'h0, m0_if.rsp_valid, m1_if.rsp_valid}, 32'h0);
        chk("rcmd ram_addr", ram_addr, 32'h0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h300, 3'b010, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h100, 3'b010, 32'h0);
        @(negedge clk);
        chk("rcmd tie", {30'h0, m0_if.req_ready, m1_if.req_ready}, 32'h2);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m0_if.rsp_valid) begin got = 1; break; end
        end
        chk("rcmd rsp", 32'(got), 32'd1);
        chk("rcmd reload", m0_if.rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            int          m;
            logic        we;
            logic [31:0] a, d, er;
            logic [2:0]  s;
            bit          lg;
            m  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            s  = sz_tab[$urandom_range(0, 9)];
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(s)) - 32'd1);
            d  = $urandom;
            lg = ref_legal(a, s);
            er = (lg && !we) ? ref_load(a, s) : 32'h0;
            run_txn($sformatf("rnd%0d", i), m, we, a, s, d, er, !lg);
        end

        chk("never two readys", 32'(dual_ready), 32'd0);
        chk("never two rsp_valids", 32'(dual_rsp), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
